// File: rtl/fixed_cmul_if.sv
// ---------------------------------------------------------------------------
// fixed_cmul_if -- operand/result handshake bundle for fixed_cmul.
//   a_re, a_im, b_re, b_im : complex operands, two's complement Q format
//   in_valid / in_ready    : operand-side handshake
//   p_re, p_im, ovf        : complex product and saturation flag
//   out_valid / out_ready  : result-side handshake
// Modports: master (operand producer / result consumer), slave (the block).
// ---------------------------------------------------------------------------
interface fixed_cmul_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] a_re;
    logic [DATA_WIDTH-1:0] a_im;
    logic [DATA_WIDTH-1:0] b_re;
    logic [DATA_WIDTH-1:0] b_im;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] p_re;
    logic [DATA_WIDTH-1:0] p_im;
    logic                  out_valid;
    logic                  out_ready;
    logic                  ovf;

    modport master (
        output a_re, a_im, b_re, b_im, in_valid, out_ready,
        input  in_ready, p_re, p_im, out_valid, ovf
    );

    modport slave (
        input  a_re, a_im, b_re, b_im, in_valid, out_ready,
        output in_ready, p_re, p_im, out_valid, ovf
    );
endinterface

// File: rtl/fixed_cmul.sv
// ---------------------------------------------------------------------------
// fixed_cmul -- pipelined signed fixed-point complex multiplier.
//   p = a * b, scaled by 2^-FRACT_WIDTH, same Q format as the operands.
//   Three stages: S1 operand register, S2 four partial products,
//   S3 sum / round / limit register driving the outputs.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fixed_cmul_if.slave (operands, product, handshakes, ovf)
// Parameters: INT_WIDTH, FRACT_WIDTH, DATA_WIDTH, ROUND (0 floor, 1 half-up).
// Optional feature: define FIXED_CMUL_SATURATE_EN to clamp results to the
// DATA_WIDTH range and report ovf; otherwise results wrap and ovf is 0.
// ---------------------------------------------------------------------------
module fixed_cmul #(
    parameter int unsigned INT_WIDTH   = 8,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH,
    parameter int unsigned ROUND       = 1
) (
    input  logic         clk,
    input  logic         rst,
    fixed_cmul_if.slave  bus
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned SW = 2 * DATA_WIDTH + 1;

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [SW-1:0] RND_C =
        (ROUND == 1) ? (SW'(1) << (FRACT_WIDTH - 1)) : '0;

    // Stage 1: operands
    logic                 r_s1_vld;
    logic signed [DW-1:0] r_a_re, r_a_im, r_b_re, r_b_im;

    // Stage 2: partial products
    logic                 r_s2_vld;
    logic signed [PW-1:0] r_m_rr, r_m_ii, r_m_ri, r_m_ir;

    // Stage 3: outputs
    logic                 r_out_vld;
    logic [DW-1:0]        r_p_re, r_p_im;
    logic                 r_ovf;

    logic                 w_adv;
    logic signed [PW-1:0] w_m_rr, w_m_ii, w_m_ri, w_m_ir;
    logic signed [SW-1:0] w_sum_re, w_sum_im;
    logic [DW-1:0]        w_lim_re, w_lim_im;
    logic                 w_ovf;

    // Whole pipeline moves as one unit whenever the output slot can drain.
    assign w_adv        = !r_out_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign bus.out_valid = r_out_vld;
    assign bus.p_re      = r_p_re;
    assign bus.p_im      = r_p_im;
    assign bus.ovf       = r_ovf;

    // Full-width signed products; operands sign-extend before multiplying.
    assign w_m_rr = PW'(r_a_re) * PW'(r_b_re);
    assign w_m_ii = PW'(r_a_im) * PW'(r_b_im);
    assign w_m_ri = PW'(r_a_re) * PW'(r_b_im);
    assign w_m_ir = PW'(r_a_im) * PW'(r_b_re);

    // One guard bit keeps the sum/difference exact.
    assign w_sum_re = SW'(r_m_rr) - SW'(r_m_ii);
    assign w_sum_im = SW'(r_m_ri) + SW'(r_m_ir);

`ifdef FIXED_CMUL_SATURATE_EN
    logic signed [SW-1:0] w_scl_re, w_scl_im;
    logic                 w_fit_re, w_fit_im;

    assign w_scl_re = (w_sum_re + RND_C) >>> FRACT_WIDTH;
    assign w_scl_im = (w_sum_im + RND_C) >>> FRACT_WIDTH;

    // Value fits when every bit from the result sign bit upward agrees.
    assign w_fit_re = (&w_scl_re[SW-1:DW-1]) || !(|w_scl_re[SW-1:DW-1]);
    assign w_fit_im = (&w_scl_im[SW-1:DW-1]) || !(|w_scl_im[SW-1:DW-1]);

    assign w_lim_re = w_fit_re ? w_scl_re[DW-1:0]
                               : {w_scl_re[SW-1], {(DW-1){~w_scl_re[SW-1]}}};
    assign w_lim_im = w_fit_im ? w_scl_im[DW-1:0]
                               : {w_scl_im[SW-1], {(DW-1){~w_scl_im[SW-1]}}};
    assign w_ovf    = !w_fit_re || !w_fit_im;
`else
    // Wrap: keep the low DATA_WIDTH bits of the scaled value.
    assign w_lim_re = DW'((w_sum_re + RND_C) >>> FRACT_WIDTH);
    assign w_lim_im = DW'((w_sum_im + RND_C) >>> FRACT_WIDTH);
    assign w_ovf    = 1'b0;
`endif

    // Valid bits and output register; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_p_re    <= '0;
            r_p_im    <= '0;
            r_ovf     <= 1'b0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.in_valid;
            r_s2_vld  <= r_s1_vld;
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_p_re <= w_lim_re;
                r_p_im <= w_lim_im;
                r_ovf  <= w_ovf;
            end
        end
    end

    // Datapath registers; only loaded for valid entries, qualified by valid bits.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            if (bus.in_valid) begin
                r_a_re <= bus.a_re;
                r_a_im <= bus.a_im;
                r_b_re <= bus.b_re;
                r_b_im <= bus.b_im;
            end
            if (r_s1_vld) begin
                r_m_rr <= w_m_rr;
                r_m_ii <= w_m_ii;
                r_m_ri <= w_m_ri;
                r_m_ir <= w_m_ir;
            end
        end
    end

endmodule

// File: tb/tb_fixed_cmul.sv
// ---------------------------------------------------------------------------
// tb_fixed_cmul -- scoreboard bench for fixed_cmul (Q8.8).
// Two instances share the same stimulus: u_dut with ROUND=1, u_dut0 with
// ROUND=0. Expected products are computed from 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_fixed_cmul;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fixed_cmul_if #(.DATA_WIDTH(DW)) bus ();
    fixed_cmul_if #(.DATA_WIDTH(DW)) bus0 ();

    assign bus0.a_re      = bus.a_re;
    assign bus0.a_im      = bus.a_im;
    assign bus0.b_re      = bus.b_re;
    assign bus0.b_im      = bus.b_im;
    assign bus0.in_valid  = bus.in_valid;
    assign bus0.out_ready = bus.out_ready;

    fixed_cmul #(.INT_WIDTH(8), .FRACT_WIDTH(8), .DATA_WIDTH(DW), .ROUND(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    fixed_cmul #(.INT_WIDTH(8), .FRACT_WIDTH(8), .DATA_WIDTH(DW), .ROUND(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic        ov;
        logic [15:0] re0;
        logic [15:0] im0;
        logic        ov0;
    } exp_t;

    typedef struct {
        logic [15:0] ar;
        logic [15:0] ai;
        logic [15:0] br;
        logic [15:0] bi;
    } stim_t;

    exp_t  sb[$];
    stim_t stim_q[$];

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scale a 64-bit exact sum to one Q8.8 component: {ovf, value}.
    function automatic logic [16:0] model_comp(input longint s, input bit rnd);
        longint v;
        v = (s + (rnd ? 64'sd128 : 64'sd0)) >>> 8;
`ifdef FIXED_CMUL_SATURATE_EN
        if (v > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (v < -64'sd32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, v[15:0]};
    endfunction

    function automatic exp_t model(input logic [15:0] ar, ai, br, bi);
        exp_t        e;
        longint      xr, xi, yr, yi, sre, sim;
        logic [16:0] t_re, t_im, t_re0, t_im0;
        xr  = longint'($signed(ar));
        xi  = longint'($signed(ai));
        yr  = longint'($signed(br));
        yi  = longint'($signed(bi));
        sre = xr * yr - xi * yi;
        sim = xr * yi + xi * yr;
        t_re  = model_comp(sre, 1'b1);
        t_im  = model_comp(sim, 1'b1);
        t_re0 = model_comp(sre, 1'b0);
        t_im0 = model_comp(sim, 1'b0);
        e.re  = t_re[15:0];
        e.im  = t_im[15:0];
        e.ov  = t_re[16] | t_im[16];
        e.re0 = t_re0[15:0];
        e.im0 = t_im0[15:0];
        e.ov0 = t_re0[16] | t_im0[16];
        return e;
    endfunction

    // Monitor: push on accept, pop and compare on delivery, check hold/ready.
    logic        hold_vld = 1'b0;
    logic [15:0] hold_re, hold_im;
    logic        hold_ov;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_vld = 1'b0;
        end else begin
            exp_t e;
            check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (hold_vld) begin
                check("hold_re", 64'(bus.p_re), 64'(hold_re));
                check("hold_im", 64'(bus.p_im), 64'(hold_im));
                check("hold_ovf", 64'(bus.ovf), 64'(hold_ov));
            end
            hold_vld = bus.out_valid && !bus.out_ready;
            hold_re  = bus.p_re;
            hold_im  = bus.p_im;
            hold_ov  = bus.ovf;
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_re", 64'(bus.p_re), 64'(e.re));
                    check("sb_im", 64'(bus.p_im), 64'(e.im));
                    check("sb_ovf", 64'(bus.ovf), 64'(e.ov));
                    check("sb_vld0", 64'(bus0.out_valid), 64'd1);
                    check("sb_re0", 64'(bus0.p_re), 64'(e.re0));
                    check("sb_im0", 64'(bus0.p_im), 64'(e.im0));
                    check("sb_ovf0", 64'(bus0.ovf), 64'(e.ov0));
                end
            end
        end
    end

    task automatic drive(input logic [15:0] ar, ai, br, bi);
        bus.a_re     = ar;
        bus.a_im     = ai;
        bus.b_re     = br;
        bus.b_im     = bi;
        bus.in_valid = 1'b1;
    endtask

    // One isolated operand set; result checked against literal constants 3 cycles on.
    task automatic directed(input string tag, input logic [15:0] ar, ai, br, bi,
                            input logic [15:0] x_re, x_im, input logic x_ov,
                            input logic [15:0] x_re0, x_im0);
        @(posedge clk); #1;
        drive(ar, ai, br, bi);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_re"},  64'(bus.p_re), 64'(x_re));
        check({tag, "_im"},  64'(bus.p_im), 64'(x_im));
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(x_ov));
        check({tag, "_re0"}, 64'(bus0.p_re), 64'(x_re0));
        check({tag, "_im0"}, 64'(bus0.p_im), 64'(x_im0));
    endtask

    // mode 1: out_ready low in stream cycles 4-6; mode 2: random back-pressure.
    task automatic run_stream(input int mode, input int max_cyc);
        int c = 0;
        while (stim_q.size() > 0 && c < max_cyc) begin
            @(posedge clk); #1;
            case (mode)
                1:       bus.out_ready = !(c >= 4 && c <= 6);
                2:       bus.out_ready = ($urandom_range(0, 9) < 7);
                default: bus.out_ready = 1'b1;
            endcase
            if (mode == 2 && $urandom_range(0, 3) == 0)
                bus.in_valid = 1'b0;
            else
                drive(stim_q[0].ar, stim_q[0].ai, stim_q[0].br, stim_q[0].bi);
            @(negedge clk);
            if (mode == 1 && c < 8)
                check("stall_in_ready", 64'(bus.in_ready), 64'(!(c >= 4 && c <= 6)));
            if (bus.in_valid && bus.in_ready)
                void'(stim_q.pop_front());
            c++;
        end
        check("stream_left", 64'(stim_q.size()), 64'd0);
        stim_q.delete();
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        stim_t s;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_p_re", 64'(bus.p_re), 64'd0);
        check("rst_p_im", 64'(bus.p_im), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        directed("conj", 16'h0100, 16'h0100, 16'h0100, 16'hFF00,
                 16'h0200, 16'h0000, 1'b0, 16'h0200, 16'h0000);
        directed("neg15", 16'hFF00, 16'h0000, 16'h0180, 16'h0000,
                 16'hFE80, 16'h0000, 1'b0, 16'hFE80, 16'h0000);
        directed("half", 16'h0001, 16'h0000, 16'h0080, 16'h0000,
                 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        directed("minval", 16'h8000, 16'h0000, 16'h0100, 16'h0000,
                 16'h8000, 16'h0000, 1'b0, 16'h8000, 16'h0000);
`ifdef FIXED_CMUL_SATURATE_EN
        directed("big", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
                 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000);
        directed("minsq", 16'h8000, 16'h0000, 16'h8000, 16'h0000,
                 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 16'h0000);
`else
        directed("big", 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
                 16'hFF00, 16'h0000, 1'b0, 16'hFF00, 16'h0000);
        directed("minsq", 16'h8000, 16'h0000, 16'h8000, 16'h0000,
                 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
`endif
        drain();

        // Eight back-to-back sets with a three-cycle downstream stall.
        for (int i = 0; i < 8; i++) begin
            s.ar = rnd_op(); s.ai = rnd_op(); s.br = rnd_op(); s.bi = rnd_op();
            stim_q.push_back(s);
        end
        run_stream(1, 100);
        drain();

        // Reset with two sets in flight: nothing from before may emerge.
        @(posedge clk); #1;
        drive(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        @(posedge clk); #1;
        drive(16'h0500, 16'h0600, 16'h0700, 16'h0800);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_vld", 64'(bus.out_valid), 64'd0);
        check("post_rst_re", 64'(bus.p_re), 64'd0);
        check("post_rst_vld0", 64'(bus0.out_valid), 64'd0);
        drain();

        // Random operands under random valid and back-pressure.
        for (int i = 0; i < 60; i++) begin
            s.ar = rnd_op(); s.ai = rnd_op(); s.br = rnd_op(); s.bi = rnd_op();
            stim_q.push_back(s);
        end
        run_stream(2, 2000);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
